id_stage_sb: RTL and testbench
==============================

// Module: id_stage_sb
// PURPOSE
//  Registered decode stage with a valid/ready interface on both sides. It decodes RV32IM + Zicsr,
//  drives the regfile/CSR read addresses, and holds the ID/EX pipeline register.
//  A register scoreboard stalls issue while a long-latency write (load, div/rem) is still pending.
//  Sits between if_id and ex. Handles jump flush, back-pressure and illegal-instruction flagging.
// PARAMETERS
//  XLEN      32  data/address width
//  REG_AW    5   GPR address width; the scoreboard holds 2**REG_AW bits, bit 0 is never set
//  CSR_AW    12  CSR address width; CSR addresses are zero-extended to XLEN on output
//  SB_EN     1   1: scoreboard active. 0: hazard is forced to 0 and pending stays all-zero
// PORTS
//  clk           in   1       clock
//  rst           in   1       reset: synchronous, active-high
//  in_valid_i    in   1       instruction valid from if_id
//  in_ready_o    out  1       stage accepts the instruction this cycle
//  inst_i        in   32      instruction word
//  inst_addr_i   in   XLEN    instruction address
//  rs1_raddr_o   out  REG_AW  GPR read address 1 (combinational, 0 if rs1 unused)
//  rs2_raddr_o   out  REG_AW  GPR read address 2 (combinational, 0 if rs2 unused)
//  rs1_rdata_i   in   XLEN    GPR read data 1
//  rs2_rdata_i   in   XLEN    GPR read data 2
//  csr_raddr_o   out  XLEN    CSR read address (combinational)
//  csr_rdata_i   in   XLEN    CSR read data
//  flush_i       in   1       jump taken in ex; kill the held and the incoming instruction
//  wb_valid_i    in   1       a long-latency result retires this cycle
//  wb_rd_i       in   REG_AW  destination of the retiring result
//  out_valid_o   out  1       ID/EX register holds a valid instruction
//  out_ready_i   in   1       ex consumes the instruction
//  out_inst_o, out_inst_addr_o, out_rs1_o, out_rs2_o, out_csr_rdata_o   out  32/XLEN  registered payload
//  out_rd_we_o   out  1       GPR write enable
//  out_rd_o      out  REG_AW  GPR write address
//  out_long_o    out  1       load or div/rem; result arrives later via wb_*
//  out_csr_we_o  out  1       CSR write enable
//  out_csr_waddr_o out XLEN   CSR write address
//  out_mem_req_o out  1       load/store bus request; equals out_valid_o & mem & ~flush_i
//  out_illegal_o out  1       opcode, funct3 or funct7 not decoded
// BEHAVIOUR
//  - Reset: out_valid_o=0. Payload=0, except out_inst_o=NOP (32'h00000013). Pending=0.
//  - Decode is combinational on inst_i. Unused source registers read x0. Illegal encodings:
//    we=0, rd=0, raddr=0, illegal=1. Illegal instructions still issue; ex raises the trap.
//  - div/divu/rem/remu: rd_we=1, long=1. Loads: rd_we=1, long=1, mem=1. Stores: mem=1, rd_we=0.
//  - hazard = SB_EN & in_valid_i & ((rs1 used & pending[rs1]) | (rs2 used & pending[rs2])).
//    A write to x0 never sets pending.
//  - in_ready_o = ~hazard & ~flush_i & (~out_valid_o | out_ready_i).
//  - Accept (in_valid_i & in_ready_o): the register loads the payload and out_valid_o=1 next cycle.
//    The latency through the stage is 1 cycle.
//  - Consume without accept: out_valid_o=0 next cycle. Hold without consume: payload stays stable.
//  - Pending set: accept & long & rd!=0 sets pending[rd]. Pending clear: wb_valid_i clears pending[wb_rd_i].
//  - Set and clear of the same bit in one cycle: set wins, because the clear retires an older write.
//  - Long-latency WAW: an accept whose rd is already pending also stalls. hazard includes pending[rd] when rd_we.
//  - flush_i: out_valid_o=0 next cycle and no accept this cycle.
//    Pending bits are NOT cleared, because in-flight loads/divs still retire.
//    A set from a flushed issue cannot occur, since there is no accept under flush.
//  - Mid-operation reset clears pending. The external long-latency units are reset on the same rst.
// STRUCTURE
//  - Package id_pkg: opcode/funct3/funct7 localparams, INST_NOP, and a decode_t struct
//    (rs1_used, rs2_used, rd_we, long, mem, csr_we, illegal).
//  - Sub-module id_decode: combinational inst -> decode_t.
//  - The top level holds the scoreboard, the hazard logic and the ID/EX register.
// TESTING
//  - add x3,x1,x2 issued with out_ready_i=1 -> out_valid_o one cycle later,
//    out_rd_o=3, out_rd_we_o=1, out_long_o=0.
//  - lw x5,0(x1), then add x6,x5,x0 -> in_ready_o=0 until wb_valid_i with wb_rd_i=5.
//    The add issues on the cycle after that.
//  - div x7,x1,x2 issued while wb_valid_i/wb_rd_i=7 for an older write -> pending[7] stays 1.
//  - out_ready_i=0 for 3 cycles with a new in_valid_i -> payload held, in_ready_o=0, no loss or duplication.
//  - flush_i together with a pending sw -> out_mem_req_o=0 that cycle, out_valid_o=0 next cycle, pending unchanged.
//  - inst 32'hFFFFFFFF -> out_illegal_o=1, out_rd_we_o=0.
//    rst mid-stall -> out_valid_o=0 and pending=0 next cycle.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode definitions for the ID stage: RV32IM + Zicsr encodings and the decode bundle.
package id_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_ADD   = 3'b000;
   localparam logic [2:0] F3_SLL   = 3'b001;
   localparam logic [2:0] F3_SR    = 3'b101;
   localparam logic [2:0] F3_PRIV  = 3'b000;
   localparam logic [2:0] F3_CSR_X = 3'b100;

   localparam logic [31:0] INST_NOP    = 32'h00000013;
   localparam logic [31:0] INST_ECALL  = 32'h00000073;
   localparam logic [31:0] INST_EBREAK = 32'h00100073;
   localparam logic [31:0] INST_MRET   = 32'h30200073;
   localparam logic [31:0] INST_WFI    = 32'h10500073;

   typedef struct packed {
      logic rs1_used;
      logic rs2_used;
      logic rd_we;
      logic long;
      logic mem;
      logic csr_we;
      logic illegal;
   } decode_t;

endpackage

// File: rtl/id_decode.sv
// Combinational RV32IM + Zicsr decoder; an illegal encoding yields only the illegal flag.
module id_decode
   import id_pkg::*;
(
   input  logic [31:0] inst_i,
   output decode_t     dec_o
);

   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       ok;

   assign opc = inst_i[6:0];
   assign f3  = inst_i[14:12];
   assign f7  = inst_i[31:25];

   always_comb begin
      dec_o = '0;
      ok    = 1'b1;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL: dec_o.rd_we = 1'b1;
         OPC_JALR: begin
            ok             = (f3 == F3_ADD);
            dec_o.rs1_used = 1'b1;
            dec_o.rd_we    = 1'b1;
         end
         OPC_BRANCH: begin
            ok             = (f3 != 3'b010) && (f3 != 3'b011);
            dec_o.rs1_used = 1'b1;
            dec_o.rs2_used = 1'b1;
         end
         OPC_LOAD: begin
            ok             = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            dec_o.rs1_used = 1'b1;
            dec_o.rd_we    = 1'b1;
            dec_o.long     = 1'b1;
            dec_o.mem      = 1'b1;
         end
         OPC_STORE: begin
            ok             = f3 inside {3'b000, 3'b001, 3'b010};
            dec_o.rs1_used = 1'b1;
            dec_o.rs2_used = 1'b1;
            dec_o.mem      = 1'b1;
         end
         OPC_OP_IMM: begin
            if (f3 == F3_SLL)     ok = (f7 == F7_BASE);
            else if (f3 == F3_SR) ok = (f7 == F7_BASE) || (f7 == F7_ALT);
            dec_o.rs1_used = 1'b1;
            dec_o.rd_we    = 1'b1;
         end
         OPC_OP: begin
            ok = (f7 == F7_BASE) || (f7 == F7_MULDIV) ||
                 ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
            dec_o.rs1_used = 1'b1;
            dec_o.rs2_used = 1'b1;
            dec_o.rd_we    = 1'b1;
            // div/divu/rem/remu occupy funct3 4..7 of the M extension
            dec_o.long     = (f7 == F7_MULDIV) && f3[2];
         end
         OPC_MISC_MEM: ok = (f3 == F3_ADD);
         OPC_SYSTEM: begin
            if (f3 == F3_PRIV) begin
               ok = inst_i inside {INST_ECALL, INST_EBREAK, INST_MRET, INST_WFI};
            end else begin
               ok             = (f3 != F3_CSR_X);
               dec_o.rd_we    = 1'b1;
               dec_o.rs1_used = ~f3[2];
               // csrrs/csrrc with a zero source only read the CSR
               dec_o.csr_we   = (f3[1:0] == 2'b01) || (inst_i[19:15] != 5'd0);
            end
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         dec_o         = '0;
         dec_o.illegal = 1'b1;
      end
   end

endmodule

// File: rtl/id_stage_sb.sv
// Decode stage with valid/ready handshakes, the ID/EX pipeline register and a long-latency
// write scoreboard that stalls RAW and WAW hazards until the result retires through wb_*.
module id_stage_sb
   import id_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CSR_AW = 12,
   parameter bit          SB_EN  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [31:0]       inst_i,
   input  logic [XLEN-1:0]   inst_addr_i,
   output logic [REG_AW-1:0] rs1_raddr_o,
   output logic [REG_AW-1:0] rs2_raddr_o,
   input  logic [XLEN-1:0]   rs1_rdata_i,
   input  logic [XLEN-1:0]   rs2_rdata_i,
   output logic [XLEN-1:0]   csr_raddr_o,
   input  logic [XLEN-1:0]   csr_rdata_i,
   input  logic              flush_i,
   input  logic              wb_valid_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [31:0]       out_inst_o,
   output logic [XLEN-1:0]   out_inst_addr_o,
   output logic [XLEN-1:0]   out_rs1_o,
   output logic [XLEN-1:0]   out_rs2_o,
   output logic [XLEN-1:0]   out_csr_rdata_o,
   output logic              out_rd_we_o,
   output logic [REG_AW-1:0] out_rd_o,
   output logic              out_long_o,
   output logic              out_csr_we_o,
   output logic [XLEN-1:0]   out_csr_waddr_o,
   output logic              out_mem_req_o,
   output logic              out_illegal_o
);

   localparam int unsigned NREG = 1 << REG_AW;

   decode_t             dec;
   logic [REG_AW-1:0]   rs1_f, rs2_f, rd_f, rd_dec;
   logic [CSR_AW-1:0]   csr_f;
   logic                csr_use, hazard, accept;
   logic [XLEN-1:0]     csr_addr;

   logic [NREG-1:0]     pending_q, pending_d;
   logic                valid_q, valid_d;
   logic [31:0]         inst_q;
   logic [XLEN-1:0]     inst_addr_q, rs1_q, rs2_q, csr_rdata_q, csr_waddr_q;
   logic                rd_we_q, long_q, csr_we_q, mem_q, illegal_q;
   logic [REG_AW-1:0]   rd_q;

   id_decode u_decode (
      .inst_i (inst_i),
      .dec_o  (dec)
   );

   assign rs1_f    = REG_AW'(inst_i[19:15]);
   assign rs2_f    = REG_AW'(inst_i[24:20]);
   assign rd_f     = REG_AW'(inst_i[11:7]);
   assign csr_f    = CSR_AW'(inst_i[31:20]);
   assign csr_use  = dec.rd_we && (inst_i[6:0] == OPC_SYSTEM);
   assign csr_addr = csr_use ? XLEN'(csr_f) : '0;
   assign rd_dec   = dec.rd_we ? rd_f : '0;

   assign rs1_raddr_o = dec.rs1_used ? rs1_f : '0;
   assign rs2_raddr_o = dec.rs2_used ? rs2_f : '0;
   assign csr_raddr_o = csr_addr;

   // RAW on either source, or WAW on a destination whose long-latency write is still in flight
   always_comb begin
      hazard = 1'b0;
      if (SB_EN && in_valid_i) begin
         hazard = (dec.rs1_used & pending_q[rs1_f]) |
                  (dec.rs2_used & pending_q[rs2_f]) |
                  (dec.rd_we    & pending_q[rd_f]);
      end
   end

   assign in_ready_o = ~hazard & ~flush_i & (~valid_q | out_ready_i);
   assign accept     = in_valid_i & in_ready_o;

   // Retirement clear is applied first so a same-cycle issue to that register keeps its bit
   always_comb begin
      pending_d = pending_q;
      if (wb_valid_i) pending_d[wb_rd_i] = 1'b0;
      if (accept && dec.long && (rd_f != '0)) pending_d[rd_f] = 1'b1;
      pending_d[0] = 1'b0;
      if (!SB_EN) pending_d = '0;
   end

   always_comb begin
      valid_d = valid_q;
      if (flush_i)          valid_d = 1'b0;
      else if (accept)      valid_d = 1'b1;
      else if (out_ready_i) valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending_q   <= '0;
         valid_q     <= 1'b0;
         inst_q      <= INST_NOP;
         inst_addr_q <= '0;
         rs1_q       <= '0;
         rs2_q       <= '0;
         csr_rdata_q <= '0;
         csr_waddr_q <= '0;
         rd_we_q     <= 1'b0;
         rd_q        <= '0;
         long_q      <= 1'b0;
         csr_we_q    <= 1'b0;
         mem_q       <= 1'b0;
         illegal_q   <= 1'b0;
      end else begin
         pending_q <= pending_d;
         valid_q   <= valid_d;
         if (accept) begin
            inst_q      <= inst_i;
            inst_addr_q <= inst_addr_i;
            rs1_q       <= rs1_rdata_i;
            rs2_q       <= rs2_rdata_i;
            csr_rdata_q <= csr_rdata_i;
            csr_waddr_q <= dec.csr_we ? csr_addr : '0;
            rd_we_q     <= dec.rd_we;
            rd_q        <= rd_dec;
            long_q      <= dec.long;
            csr_we_q    <= dec.csr_we;
            mem_q       <= dec.mem;
            illegal_q   <= dec.illegal;
         end
      end
   end

   assign out_valid_o     = valid_q;
   assign out_inst_o      = inst_q;
   assign out_inst_addr_o = inst_addr_q;
   assign out_rs1_o       = rs1_q;
   assign out_rs2_o       = rs2_q;
   assign out_csr_rdata_o = csr_rdata_q;
   assign out_rd_we_o     = rd_we_q;
   assign out_rd_o        = rd_q;
   assign out_long_o      = long_q;
   assign out_csr_we_o    = csr_we_q;
   assign out_csr_waddr_o = csr_waddr_q;
   assign out_mem_req_o   = valid_q & mem_q & ~flush_i;
   assign out_illegal_o   = illegal_q;

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed bench for id_stage_sb: issue, scoreboard stalls, back-pressure, flush, illegal, reset.
module tb_id_stage_sb;

   localparam logic [31:0] I_ADD3   = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_LW5    = 32'h0000A283; // lw   x5,0(x1)
   localparam logic [31:0] I_ADD6   = 32'h00028333; // add  x6,x5,x0
   localparam logic [31:0] I_DIV7   = 32'h0220C3B3; // div  x7,x1,x2
   localparam logic [31:0] I_SW     = 32'h0020A023; // sw   x2,0(x1)
   localparam logic [31:0] I_ADDI9  = 32'h00500493; // addi x9,x0,5
   localparam logic [31:0] I_CSRRW  = 32'h30009473; // csrrw x8,mstatus,x1
   localparam logic [31:0] I_BAD    = 32'hFFFFFFFF;
   localparam logic [31:0] NOP      = 32'h00000013;
   localparam logic [31:0] CSR_DATA = 32'hC5C5C5C5;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_i, in_ready_o;
   logic [31:0] inst_i, inst_addr_i;
   logic [4:0]  rs1_raddr_o, rs2_raddr_o;
   logic [31:0] rs1_rdata_i, rs2_rdata_i, csr_raddr_o, csr_rdata_i;
   logic        flush_i, wb_valid_i;
   logic [4:0]  wb_rd_i;
   logic        out_valid_o, out_ready_i;
   logic [31:0] out_inst_o, out_inst_addr_o, out_rs1_o, out_rs2_o, out_csr_rdata_o;
   logic        out_rd_we_o;
   logic [4:0]  out_rd_o;
   logic        out_long_o, out_csr_we_o;
   logic [31:0] out_csr_waddr_o;
   logic        out_mem_req_o, out_illegal_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Register file stand-in: xN reads as N*0x11, so x0 reads 0
   assign rs1_rdata_i = 32'(rs1_raddr_o) * 32'h11;
   assign rs2_rdata_i = 32'(rs2_raddr_o) * 32'h11;
   assign csr_rdata_i = CSR_DATA;

   id_stage_sb dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .inst_i          (inst_i),
      .inst_addr_i     (inst_addr_i),
      .rs1_raddr_o     (rs1_raddr_o),
      .rs2_raddr_o     (rs2_raddr_o),
      .rs1_rdata_i     (rs1_rdata_i),
      .rs2_rdata_i     (rs2_rdata_i),
      .csr_raddr_o     (csr_raddr_o),
      .csr_rdata_i     (csr_rdata_i),
      .flush_i         (flush_i),
      .wb_valid_i      (wb_valid_i),
      .wb_rd_i         (wb_rd_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .out_inst_o      (out_inst_o),
      .out_inst_addr_o (out_inst_addr_o),
      .out_rs1_o       (out_rs1_o),
      .out_rs2_o       (out_rs2_o),
      .out_csr_rdata_o (out_csr_rdata_o),
      .out_rd_we_o     (out_rd_we_o),
      .out_rd_o        (out_rd_o),
      .out_long_o      (out_long_o),
      .out_csr_we_o    (out_csr_we_o),
      .out_csr_waddr_o (out_csr_waddr_o),
      .out_mem_req_o   (out_mem_req_o),
      .out_illegal_o   (out_illegal_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] inst, input logic [31:0] addr);
      in_valid_i  = 1'b1;
      inst_i      = inst;
      inst_addr_i = addr;
   endtask

   initial begin
      rst = 1'b1; in_valid_i = 1'b0; inst_i = NOP; inst_addr_i = '0;
      flush_i = 1'b0; wb_valid_i = 1'b0; wb_rd_i = '0; out_ready_i = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("reset_valid",   32'(out_valid_o), 32'd0);
      chk("reset_inst",    out_inst_o, NOP);
      chk("reset_rd",      32'(out_rd_o), 32'd0);
      chk("reset_pending", dut.pending_q, 32'd0);

      // Plain ALU issue
      present(I_ADD3, 32'h100); #1;
      chk("add_ready", 32'(in_ready_o), 32'd1);
      chk("add_raddr1", 32'(rs1_raddr_o), 32'd1);
      chk("add_raddr2", 32'(rs2_raddr_o), 32'd2);
      tick(); in_valid_i = 1'b0; #1;
      chk("add_valid", 32'(out_valid_o), 32'd1);
      chk("add_inst",  out_inst_o, I_ADD3);
      chk("add_addr",  out_inst_addr_o, 32'h100);
      chk("add_rd",    32'(out_rd_o), 32'd3);
      chk("add_we",    32'(out_rd_we_o), 32'd1);
      chk("add_long",  32'(out_long_o), 32'd0);
      chk("add_rs1",   out_rs1_o, 32'h11);
      chk("add_rs2",   out_rs2_o, 32'h22);
      tick();
      chk("add_drain", 32'(out_valid_o), 32'd0);

      // Load-use stall released by write-back
      present(I_LW5, 32'h104); tick();
      present(I_ADD6, 32'h108); #1;
      chk("lw_long",    32'(out_long_o), 32'd1);
      chk("lw_memreq",  32'(out_mem_req_o), 32'd1);
      chk("lw_pending", dut.pending_q, 32'h20);
      chk("lu_stall0",  32'(in_ready_o), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("lu_stall%0d", i + 1), 32'(in_ready_o), 32'd0);
      end
      wb_valid_i = 1'b1; wb_rd_i = 5'd5; #1;
      chk("lu_wb_cycle", 32'(in_ready_o), 32'd0);
      tick(); wb_valid_i = 1'b0; #1;
      chk("lu_release", 32'(in_ready_o), 32'd1);
      chk("lu_pend_clr", dut.pending_q, 32'd0);
      chk("lu_not_yet", 32'(out_valid_o), 32'd0);
      tick(); in_valid_i = 1'b0; #1;
      chk("lu_issue", 32'(out_valid_o), 32'd1);
      chk("lu_inst",  out_inst_o, I_ADD6);
      chk("lu_rs1",   out_rs1_o, 32'h55);
      chk("lu_rs2",   out_rs2_o, 32'h00);

      // div issued while an older write to x7 retires: the set must win
      present(I_DIV7, 32'h10C); wb_valid_i = 1'b1; wb_rd_i = 5'd7; #1;
      chk("div_ready", 32'(in_ready_o), 32'd1);
      tick(); wb_valid_i = 1'b0; #1;
      chk("div_pending", dut.pending_q, 32'h80);
      chk("div_long",    32'(out_long_o), 32'd1);
      chk("div_we",      32'(out_rd_we_o), 32'd1);
      chk("waw_stall",   32'(in_ready_o), 32'd0);
      in_valid_i = 1'b0; wb_valid_i = 1'b1; wb_rd_i = 5'd7;
      tick(); wb_valid_i = 1'b0; #1;
      chk("div_retired", dut.pending_q, 32'd0);
      chk("div_drain",   32'(out_valid_o), 32'd0);

      // Back-pressure: addi held for 3 cycles while csrrw waits
      out_ready_i = 1'b0;
      present(I_ADDI9, 32'h110); #1;
      chk("bp_first_ready", 32'(in_ready_o), 32'd1);
      tick();
      present(I_CSRRW, 32'h114); #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("bp_valid%0d", i), 32'(out_valid_o), 32'd1);
         chk($sformatf("bp_inst%0d", i),  out_inst_o, I_ADDI9);
         chk($sformatf("bp_ready%0d", i), 32'(in_ready_o), 32'd0);
         tick();
      end
      chk("bp_rd_held", 32'(out_rd_o), 32'd9);
      out_ready_i = 1'b1; #1;
      chk("bp_release",  32'(in_ready_o), 32'd1);
      chk("csr_raddr",   csr_raddr_o, 32'h300);
      tick(); in_valid_i = 1'b0; #1;
      chk("csr_inst",    out_inst_o, I_CSRRW);
      chk("csr_we",      32'(out_csr_we_o), 32'd1);
      chk("csr_waddr",   out_csr_waddr_o, 32'h300);
      chk("csr_rdata",   out_csr_rdata_o, CSR_DATA);
      chk("csr_rd",      32'(out_rd_o), 32'd8);
      chk("csr_rs1",     out_rs1_o, 32'h11);
      tick();
      chk("bp_no_dup",   32'(out_valid_o), 32'd0);

      // Flush with a held store, pending load left untouched
      present(I_LW5, 32'h118); tick();
      present(I_SW, 32'h11C); #1;
      chk("sw_ready", 32'(in_ready_o), 32'd1);
      tick(); in_valid_i = 1'b0; out_ready_i = 1'b0; #1;
      chk("sw_memreq", 32'(out_mem_req_o), 32'd1);
      chk("sw_we",     32'(out_rd_we_o), 32'd0);
      flush_i = 1'b1; present(I_ADDI9, 32'h120); #1;
      chk("fl_memreq", 32'(out_mem_req_o), 32'd0);
      chk("fl_ready",  32'(in_ready_o), 32'd0);
      tick(); flush_i = 1'b0; in_valid_i = 1'b0; #1;
      chk("fl_valid",   32'(out_valid_o), 32'd0);
      chk("fl_pending", dut.pending_q, 32'h20);

      // Illegal encoding still issues
      out_ready_i = 1'b1;
      present(I_BAD, 32'h124); #1;
      chk("ill_raddr1", 32'(rs1_raddr_o), 32'd0);
      chk("ill_raddr2", 32'(rs2_raddr_o), 32'd0);
      chk("ill_ready",  32'(in_ready_o), 32'd1);
      tick(); in_valid_i = 1'b0; #1;
      chk("ill_valid", 32'(out_valid_o), 32'd1);
      chk("ill_flag",  32'(out_illegal_o), 32'd1);
      chk("ill_we",    32'(out_rd_we_o), 32'd0);
      chk("ill_rd",    32'(out_rd_o), 32'd0);

      // Reset in the middle of a scoreboard stall
      out_ready_i = 1'b0;
      present(I_ADD6, 32'h128); #1;
      chk("rs_stall", 32'(in_ready_o), 32'd0);
      rst = 1'b1;
      tick(); rst = 1'b0; #1;
      chk("rs_valid",   32'(out_valid_o), 32'd0);
      chk("rs_pending", dut.pending_q, 32'd0);
      chk("rs_inst",    out_inst_o, NOP);
      chk("rs_ready",   32'(in_ready_o), 32'd1);
      in_valid_i = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
